// File: rtl/branch_predictor_if.sv
// Fetch/execute-side signal bundle for the branch predictor.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is sampled or driven each cycle.
interface branch_predictor_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
);
  logic [WIDTH-1:0]     PC_F;
  logic                 predictTaken_F;
  logic [WIDTH-1:0]     predictTarget_F;
  logic                 update_E;
  logic [WIDTH-1:0]     PC_E;
  logic [WIDTH-1:0]     PCPlus4_E;
  logic                 taken_E;
  logic [WIDTH-1:0]     target_E;
  logic                 predTaken_E;
  logic [WIDTH-1:0]     predTarget_E;
  logic                 mispredict_E;
  logic [WIDTH-1:0]     redirectPC_E;
  logic [CNT_WIDTH-1:0] branchCount;
  logic [CNT_WIDTH-1:0] mispredictCount;

  modport master (
    output PC_F, update_E, PC_E, PCPlus4_E, taken_E, target_E, predTaken_E, predTarget_E,
    input  predictTaken_F, predictTarget_F, mispredict_E, redirectPC_E,
           branchCount, mispredictCount
  );

  modport slave (
    input  PC_F, update_E, PC_E, PCPlus4_E, taken_E, target_E, predTaken_E, predTarget_E,
    output predictTaken_F, predictTarget_F, mispredict_E, redirectPC_E,
           branchCount, mispredictCount
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters plus branch/mispredict counters.
// Latency: lookup and mispredict detection are combinational; training lands next cycle.
// Backpressure: none; one lookup and one update accepted every cycle.
module branch_predictor #(
  parameter int WIDTH     = 32,
  parameter int ENTRIES   = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  branch_predictor_if.slave bp
);
  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = WIDTH - IDX - 2;

  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [WIDTH-1:0] target_q [ENTRIES];
  logic [WIDTH-1:0] target_d [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [1:0]       ctr_d    [ENTRIES];

  logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0] misp_cnt_q, misp_cnt_d;

  logic [IDX-1:0]   idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             hit_f, hit_e;
  logic             mispredict;

  // Byte-offset bits never participate in index or tag.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.PC_F[1:0], bp.PC_E[1:0]};

  assign idx_f = bp.PC_F[IDX+1:2];
  assign tag_f = bp.PC_F[WIDTH-1:IDX+2];
  assign idx_e = bp.PC_E[IDX+1:2];
  assign tag_e = bp.PC_E[WIDTH-1:IDX+2];

  assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

  assign bp.predictTaken_F  = hit_f && ctr_q[idx_f][1];
  assign bp.predictTarget_F = hit_f ? target_q[idx_f] : '0;

  assign mispredict = bp.update_E &&
                      ((bp.taken_E != bp.predTaken_E) ||
                       (bp.taken_E && (bp.predTarget_E != bp.target_E)));

  assign bp.mispredict_E    = mispredict;
  assign bp.redirectPC_E    = (bp.update_E && bp.taken_E) ? bp.target_E : bp.PCPlus4_E;
  assign bp.branchCount     = branch_cnt_q;
  assign bp.mispredictCount = misp_cnt_q;

  always_comb begin
    valid_d      = valid_q;
    tag_d        = tag_q;
    target_d     = target_q;
    ctr_d        = ctr_q;
    branch_cnt_d = branch_cnt_q;
    misp_cnt_d   = misp_cnt_q;
    if (bp.update_E) begin
      if (hit_e) begin
        if (bp.taken_E) begin
          if (ctr_q[idx_e] != 2'b11) ctr_d[idx_e] = ctr_q[idx_e] + 2'd1;
          target_d[idx_e] = bp.target_E;
        end else if (ctr_q[idx_e] != 2'b00) begin
          ctr_d[idx_e] = ctr_q[idx_e] - 2'd1;
        end
      end else if (bp.taken_E) begin
        // Taken miss evicts whatever aliased into this slot.
        valid_d[idx_e]  = 1'b1;
        tag_d[idx_e]    = tag_e;
        target_d[idx_e] = bp.target_E;
        ctr_d[idx_e]    = 2'b10;
      end
      if (branch_cnt_q != {CNT_WIDTH{1'b1}}) branch_cnt_d = branch_cnt_q + 1'b1;
      if (mispredict && (misp_cnt_q != {CNT_WIDTH{1'b1}})) misp_cnt_d = misp_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
      branch_cnt_q <= '0;
      misp_cnt_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      target_q     <= target_d;
      ctr_q        <= ctr_d;
      branch_cnt_q <= branch_cnt_d;
      misp_cnt_q   <= misp_cnt_d;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: default instance plus a 3-bit-counter instance
// fed the same stimulus; expected values are queued at drive time and checked mid-cycle.
module tb_branch_predictor;
  localparam int K_PT = 0, K_PTGT = 1, K_MISP = 2, K_REDIR = 3;
  localparam int K_BCNT = 4, K_MCNT = 5, K_BCNT3 = 6, K_MCNT3 = 7;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb_q[$];
  int   n_asserts = 0;
  int   n_fail    = 0;

  always #5 clk = ~clk;

  branch_predictor_if #(.WIDTH(32), .CNT_WIDTH(32)) bp_if ();
  branch_predictor_if #(.WIDTH(32), .CNT_WIDTH(3))  bp_if3 ();

  assign bp_if3.PC_F         = bp_if.PC_F;
  assign bp_if3.update_E     = bp_if.update_E;
  assign bp_if3.PC_E         = bp_if.PC_E;
  assign bp_if3.PCPlus4_E    = bp_if.PCPlus4_E;
  assign bp_if3.taken_E      = bp_if.taken_E;
  assign bp_if3.target_E     = bp_if.target_E;
  assign bp_if3.predTaken_E  = bp_if.predTaken_E;
  assign bp_if3.predTarget_E = bp_if.predTarget_E;

  branch_predictor #(.WIDTH(32), .ENTRIES(16), .CNT_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp_if)
  );

  branch_predictor #(.WIDTH(32), .ENTRIES(16), .CNT_WIDTH(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bp  (bp_if3)
  );

  function automatic logic [31:0] observe(int kind);
    case (kind)
      K_PT:    return {31'b0, bp_if.predictTaken_F};
      K_PTGT:  return bp_if.predictTarget_F;
      K_MISP:  return {31'b0, bp_if.mispredict_E};
      K_REDIR: return bp_if.redirectPC_E;
      K_BCNT:  return bp_if.branchCount;
      K_MCNT:  return bp_if.mispredictCount;
      K_BCNT3: return {29'b0, bp_if3.branchCount};
      K_MCNT3: return {29'b0, bp_if3.mispredictCount};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int kind, input logic [31:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = val;
    sb_q.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = observe(e.kind);
      n_asserts++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                     input logic ptaken, input logic [31:0] ptgt);
    bp_if.update_E     = 1'b1;
    bp_if.PC_E         = pc;
    bp_if.PCPlus4_E    = pc + 32'd4;
    bp_if.taken_E      = taken;
    bp_if.target_E     = tgt;
    bp_if.predTaken_E  = ptaken;
    bp_if.predTarget_E = ptgt;
  endtask

  task automatic noupd(input logic [31:0] pc4);
    bp_if.update_E     = 1'b0;
    bp_if.PC_E         = pc4 - 32'd4;
    bp_if.PCPlus4_E    = pc4;
    bp_if.taken_E      = 1'b1;
    bp_if.target_E     = 32'h0000_0999;
    bp_if.predTaken_E  = 1'b0;
    bp_if.predTarget_E = 32'h0;
  endtask

  initial begin
    rst         = 1'b1;
    bp_if.PC_F  = 32'h0;
    noupd(32'h4);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    bp_if.PC_F = 32'h100;
    expect_val("rst_pt", K_PT, 0);
    expect_val("rst_ptgt", K_PTGT, 0);
    expect_val("rst_bcnt", K_BCNT, 0);
    expect_val("rst_mcnt", K_MCNT, 0);
    expect_val("idle_misp", K_MISP, 0);
    expect_val("idle_redir", K_REDIR, 32'h4);
    cyc();

    // Allocate 0x40 -> 0x80; lookup in the same cycle still misses
    bp_if.PC_F = 32'h40;
    upd(32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
    expect_val("alloc_misp", K_MISP, 1);
    expect_val("alloc_redir", K_REDIR, 32'h80);
    expect_val("alloc_same_cycle_pt", K_PT, 0);
    cyc();

    noupd(32'h44);
    expect_val("alloc_pt", K_PT, 1);
    expect_val("alloc_ptgt", K_PTGT, 32'h80);
    expect_val("alloc_bcnt", K_BCNT, 1);
    expect_val("alloc_mcnt", K_MCNT, 1);
    expect_val("noupd_misp", K_MISP, 0);
    expect_val("noupd_redir", K_REDIR, 32'h44);
    cyc();

    // Two taken updates saturate ctr at 11
    for (int i = 0; i < 2; i++) begin
      upd(32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
      expect_val("train_misp", K_MISP, 0);
      cyc();
    end

    // First not-taken: 11 -> 10, still predicts taken
    upd(32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
    expect_val("nt1_misp", K_MISP, 1);
    expect_val("nt1_redir", K_REDIR, 32'h44);
    cyc();
    noupd(32'h44);
    expect_val("nt1_pt", K_PT, 1);
    expect_val("nt1_ptgt", K_PTGT, 32'h80);
    cyc();

    // Second not-taken: 10 -> 01, predicts not taken but target kept
    upd(32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
    expect_val("nt2_misp", K_MISP, 1);
    expect_val("nt2_redir", K_REDIR, 32'h44);
    cyc();
    noupd(32'h44);
    expect_val("nt2_pt", K_PT, 0);
    expect_val("nt2_ptgt", K_PTGT, 32'h80);
    expect_val("nt2_bcnt", K_BCNT, 5);
    expect_val("nt2_mcnt", K_MCNT, 3);
    cyc();

    // Target mismatch on a taken branch
    upd(32'h40, 1'b1, 32'hC0, 1'b1, 32'h80);
    expect_val("tgt_misp", K_MISP, 1);
    expect_val("tgt_redir", K_REDIR, 32'hC0);
    cyc();
    noupd(32'h44);
    expect_val("tgt_pt", K_PT, 1);
    expect_val("tgt_ptgt", K_PTGT, 32'hC0);
    cyc();

    // Aliasing: 0x440 shares index 0 with 0x40
    upd(32'h40, 1'b1, 32'hC0, 1'b1, 32'hC0);
    expect_val("alias_train_misp", K_MISP, 0);
    cyc();
    upd(32'h440, 1'b1, 32'h500, 1'b0, 32'h0);
    expect_val("alias_alloc_misp", K_MISP, 1);
    expect_val("alias_alloc_redir", K_REDIR, 32'h500);
    cyc();
    noupd(32'h44);
    expect_val("alias_old_pt", K_PT, 0);
    expect_val("alias_old_ptgt", K_PTGT, 0);
    cyc();
    bp_if.PC_F = 32'h440;
    expect_val("alias_new_pt", K_PT, 1);
    expect_val("alias_new_ptgt", K_PTGT, 32'h500);
    cyc();
    upd(32'h840, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_val("ntmiss_misp", K_MISP, 0);
    expect_val("ntmiss_redir", K_REDIR, 32'h844);
    cyc();
    noupd(32'h44);
    expect_val("ntmiss_pt", K_PT, 1);
    expect_val("ntmiss_ptgt", K_PTGT, 32'h500);
    cyc();
    // One decrement from freshly allocated weakly-taken lands at 01
    upd(32'h440, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_val("alias_dec_misp", K_MISP, 0);
    cyc();
    noupd(32'h44);
    expect_val("alias_dec_pt", K_PT, 0);
    expect_val("alias_bcnt", K_BCNT, 10);
    expect_val("alias_mcnt", K_MCNT, 5);
    cyc();

    // Simultaneous lookup and update: lookup sees pre-update state
    upd(32'h440, 1'b1, 32'h500, 1'b0, 32'h500);
    expect_val("simul_pt", K_PT, 0);
    expect_val("simul_misp", K_MISP, 1);
    cyc();
    noupd(32'h44);
    expect_val("simul_after_pt", K_PT, 1);
    expect_val("pre_rst_bcnt", K_BCNT, 11);
    expect_val("pre_rst_mcnt", K_MCNT, 6);
    expect_val("pre_rst_bcnt3", K_BCNT3, 7);
    expect_val("pre_rst_mcnt3", K_MCNT3, 6);
    cyc();

    // Reset with an update in the same cycle: reset wins
    rst = 1'b1;
    bp_if.PC_F = 32'h80;
    upd(32'h80, 1'b1, 32'h200, 1'b0, 32'h0);
    expect_val("rstupd_misp", K_MISP, 1);
    expect_val("rstupd_redir", K_REDIR, 32'h200);
    cyc();
    rst = 1'b0;
    noupd(32'h44);
    expect_val("rstupd_pt", K_PT, 0);
    expect_val("rstupd_ptgt", K_PTGT, 0);
    expect_val("rstupd_bcnt", K_BCNT, 0);
    expect_val("rstupd_mcnt", K_MCNT, 0);
    expect_val("rstupd_bcnt3", K_BCNT3, 0);
    cyc();
    bp_if.PC_F = 32'h440;
    expect_val("rst_clear_pt", K_PT, 0);
    expect_val("rst_clear_ptgt", K_PTGT, 0);
    cyc();

    // Counter saturation on the 3-bit instance
    for (int i = 0; i < 9; i++) begin
      upd(32'h100, 1'b1, 32'h300, 1'b0, 32'h0);
      if (i == 6) begin
        expect_val("sat_bcnt3_6", K_BCNT3, 6);
        expect_val("sat_mcnt3_6", K_MCNT3, 6);
      end
      cyc();
    end
    noupd(32'h44);
    expect_val("sat_bcnt3", K_BCNT3, 7);
    expect_val("sat_mcnt3", K_MCNT3, 7);
    expect_val("sat_bcnt", K_BCNT, 9);
    expect_val("sat_mcnt", K_MCNT, 9);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
